// File: rtl/flag_register_unit.sv
// Architectural O/S/C/Z flag holder: masked ALU writeback, in-flight writer count, branch handshake.
// Define FLAG_BYPASS_EN to grant on the post-update count, saving one cycle of branch latency.
module flag_register_unit #(
    parameter int unsigned PEND_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_stall,
    input  logic              wb_valid,
    input  logic [3:0]        wb_mask,
    input  logic              alu_O,
    input  logic              alu_S,
    input  logic              alu_C,
    input  logic              alu_Z,
    input  logic              br_req,
    output logic              br_ack,
    output logic              O,
    output logic              S,
    output logic              C,
    output logic              Z,
    output logic [PEND_W-1:0] pending,
    output logic              wb_err
);

    localparam logic [PEND_W-1:0] PendMax = '1;

    typedef enum logic [1:0] {StIdle, StWait, StGrant} state_e;

    state_e            state_q;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              issue_ok, retire, pend_zero;

    assign issue_stall = (pend_q == PendMax);
    assign issue_ok    = issue_valid && !issue_stall;
    assign retire      = wb_valid && (pend_q != '0);
    assign pending     = pend_q;

    always_comb begin
        pend_d = pend_q;
        if (issue_ok && !retire) begin
            pend_d = pend_q + 1'b1;
        end else if (!issue_ok && retire) begin
            pend_d = pend_q - 1'b1;
        end
    end

`ifdef FLAG_BYPASS_EN
    // Grant at the same edge as the final retire; the fresh flags land with the ack.
    assign pend_zero = (pend_d == '0);
`else
    assign pend_zero = (pend_q == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            O      <= 1'b0;
            S      <= 1'b0;
            C      <= 1'b0;
            Z      <= 1'b0;
            wb_err <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (retire) begin
                if (wb_mask[0]) O <= alu_O;
                if (wb_mask[1]) S <= alu_S;
                if (wb_mask[2]) C <= alu_C;
                if (wb_mask[3]) Z <= alu_Z;
            end
            if (wb_valid && (pend_q == '0)) begin
                wb_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            br_ack  <= 1'b0;
        end else begin
            br_ack <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (br_req) begin
                        if (pend_zero) begin
                            state_q <= StGrant;
                            br_ack  <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (pend_zero) begin
                        state_q <= StGrant;
                        br_ack  <= 1'b1;
                    end
                end
                StGrant: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_flag_register_unit.sv
// Directed self-checking bench for flag_register_unit; expected values are hand-computed.
module tb_flag_register_unit;

`ifdef FLAG_BYPASS_EN
    localparam int AckAt = 1;
`else
    localparam int AckAt = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 1'b0;
    logic       issue_stall;
    logic       wb_valid = 1'b0;
    logic [3:0] wb_mask = 4'b0000;
    logic       alu_O = 1'b0, alu_S = 1'b0, alu_C = 1'b0, alu_Z = 1'b0;
    logic       br_req = 1'b0;
    logic       br_ack;
    logic       O, S, C, Z;
    logic [2:0] pending;
    logic       wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    flag_register_unit #(.PEND_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_stall (issue_stall),
        .wb_valid    (wb_valid),
        .wb_mask     (wb_mask),
        .alu_O       (alu_O),
        .alu_S       (alu_S),
        .alu_C       (alu_C),
        .alu_Z       (alu_Z),
        .br_req      (br_req),
        .br_ack      (br_ack),
        .O           (O),
        .S           (S),
        .C           (C),
        .Z           (Z),
        .pending     (pending),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // alu values given in {Z,C,S,O} order, matching wb_mask bit positions
    task automatic set_alu(input logic [3:0] zcso);
        {alu_Z, alu_C, alu_S, alu_O} = zcso;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if ({Z, C, S, O} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {Z, C, S, O});
        end
        n_checks++;
        if (pending !== 3'd0 || br_ack !== 1'b0 || wb_err !== 1'b0 || issue_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got pending=%0d ack=%b err=%b stall=%b want 0 0 0 0",
                     pending, br_ack, wb_err, issue_stall);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_masked_write();
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_mask = 4'b1010; set_alu(4'b1111);
        tick();
        wb_valid = 1'b0;
        n_checks++;
        if ({Z, C, S, O} !== 4'b1010 || pending !== 3'd0) begin
            n_fail++;
            $display("FAIL masked_zs: got zcso=%b pending=%0d want 1010 0", {Z, C, S, O}, pending);
        end
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_mask = 4'b0101; set_alu(4'b0101);
        tick();
        n_checks++;
        if ({Z, C, S, O} !== 4'b1111) begin
            n_fail++; $display("FAIL masked_co: got zcso=%b want 1111", {Z, C, S, O});
        end
        wb_valid = 1'b0;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_mask = 4'b0000; set_alu(4'b0000);
        tick();
        wb_valid = 1'b0;
        n_checks++;
        if ({Z, C, S, O} !== 4'b1111 || pending !== 3'd0 || wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_zero_retire: got zcso=%b pending=%0d err=%b want 1111 0 0",
                     {Z, C, S, O}, pending, wb_err);
        end
    endtask

    task automatic test_immediate_grant();
        br_req = 1'b1;
        tick();
        n_checks++;
        if (br_ack !== 1'b1) begin
            n_fail++; $display("FAIL imm_ack: got %b want 1", br_ack);
        end
        br_req = 1'b0;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        n_checks++;
        if (br_ack !== 1'b0 || pending !== 3'd1) begin
            n_fail++;
            $display("FAIL imm_after: got ack=%b pending=%0d want 0 1", br_ack, pending);
        end
        wb_valid = 1'b1; wb_mask = 4'b0000;
        tick();
        wb_valid = 1'b0;
        n_checks++;
        if (br_ack !== 1'b0 || pending !== 3'd0) begin
            n_fail++;
            $display("FAIL imm_idle: got ack=%b pending=%0d want 0 0", br_ack, pending);
        end
    endtask

    task automatic test_handshake();
        issue_valid = 1'b1;
        tick();
        br_req = 1'b1;
        tick();
        issue_valid = 1'b0;
        tick();
        n_checks++;
        if (br_ack !== 1'b0 || pending !== 3'd2) begin
            n_fail++;
            $display("FAIL hs_wait: got ack=%b pending=%0d want 0 2", br_ack, pending);
        end
        wb_valid = 1'b1; wb_mask = 4'b1111; set_alu(4'b1001);
        tick();
        n_checks++;
        if (br_ack !== 1'b0 || pending !== 3'd1) begin
            n_fail++;
            $display("FAIL hs_first_wb: got ack=%b pending=%0d want 0 1", br_ack, pending);
        end
        set_alu(4'b0110);
        tick();
        wb_valid = 1'b0;
        n_checks++;
        if ({Z, C, S, O} !== 4'b0110 || pending !== 3'd0) begin
            n_fail++;
            $display("FAIL hs_flags: got zcso=%b pending=%0d want 0110 0", {Z, C, S, O}, pending);
        end
        for (int k = 1; k <= 3; k++) begin
            n_checks++;
            if (br_ack !== (k == AckAt)) begin
                n_fail++;
                $display("FAIL hs_ack_cycle%0d: got %b want %b", k, br_ack, (k == AckAt));
            end
            if (k == AckAt) br_req = 1'b0;
            tick();
        end
        br_req = 1'b0;
    endtask

    task automatic test_full_counter();
        issue_valid = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (pending !== 3'd7 || issue_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL full: got pending=%0d stall=%b want 7 1", pending, issue_stall);
        end
        tick();
        n_checks++;
        if (pending !== 3'd7) begin
            n_fail++; $display("FAIL full_refuse: got pending=%0d want 7", pending);
        end
        wb_valid = 1'b1; wb_mask = 4'b0000;
        tick();
        n_checks++;
        if (pending !== 3'd6 || issue_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL full_issue_wb: got pending=%0d stall=%b want 6 0", pending, issue_stall);
        end
        tick();
        n_checks++;
        if (pending !== 3'd6) begin
            n_fail++; $display("FAIL issue_wb_at6: got pending=%0d want 6", pending);
        end
        issue_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        wb_valid = 1'b0;
        n_checks++;
        if (pending !== 3'd0 || wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got pending=%0d err=%b want 0 0", pending, wb_err);
        end
    endtask

    task automatic test_illegal_wb();
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_mask = 4'b1111; set_alu(4'b0011);
        tick();
        wb_mask = 4'b1111; set_alu(4'b1100);
        tick();
        wb_valid = 1'b0;
        n_checks++;
        if ({Z, C, S, O} !== 4'b0011 || pending !== 3'd0 || wb_err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_wb: got zcso=%b pending=%0d err=%b want 0011 0 1",
                     {Z, C, S, O}, pending, wb_err);
        end
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (wb_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %b want 1", wb_err);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (wb_err !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: got %b want 0", wb_err);
        end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_mask = 4'b1111; set_alu(4'b1111);
        tick();
        wb_valid = 1'b0;
        br_req = 1'b1;
        tick();
        tick();
        n_checks++;
        if (pending !== 3'd3 || {Z, C, S, O} !== 4'b1111 || br_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset: got pending=%0d zcso=%b ack=%b want 3 1111 0",
                     pending, {Z, C, S, O}, br_ack);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({Z, C, S, O} !== 4'b0000 || pending !== 3'd0 || br_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got zcso=%b pending=%0d ack=%b want 0000 0 0",
                     {Z, C, S, O}, pending, br_ack);
        end
        br_req = 1'b0;
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (br_ack !== 1'b0) begin
                n_fail++; $display("FAIL no_ack_after_reset%0d: got %b want 0", i, br_ack);
            end
        end
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_immediate_grant();
        test_handshake();
        test_full_counter();
        test_illegal_wb();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
